// File: rtl/ram8_pkg.sv
// Shared constants and FSM state type for the ram8 register file and its
// sequencing front end.
package ram8_pkg;

  localparam int unsigned DW         = 32;
  localparam int unsigned AW         = 3;
  localparam int unsigned RAM8_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_FIN     = 3'd4
  } ram8_ctrl_state_t;

endpackage

// File: rtl/ram8_ctrl_if.sv
// Command, write-data and read-data streams of ram8_ctrl, plus its done/err
// status pulses. The master side is the bus initiator.
interface ram8_ctrl_if #(
  parameter int unsigned DW = ram8_pkg::DW,
  parameter int unsigned AW = ram8_pkg::AW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, err
  );

endinterface

// File: rtl/ram8.sv
// 8 x 32-bit register file: synchronous write when en && !read, asynchronous
// read of the addressed word.
module ram8 #(
  parameter int unsigned DW = ram8_pkg::DW,
  parameter int unsigned AW = ram8_pkg::AW
) (
  input  logic          clk,
  input  logic          en,
  input  logic          read,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en && !read) begin
      mem[address] <= in;
    end
  end

  assign out = mem[address];

endmodule

// File: rtl/ram8_ctrl.sv
// Burst sequencer in front of ram8: turns one accepted command into a run of
// single-word RAM accesses with wrapping address and streamed data.
module ram8_ctrl #(
  parameter int unsigned DW = ram8_pkg::DW,
  parameter int unsigned AW = ram8_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  ram8_ctrl_if.slave    bus,
  output logic          mem_en,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  import ram8_pkg::*;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(1 << AW);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  ram8_ctrl_state_t state;
  logic [AW-1:0]    ptr;
  logic [AW:0]      cnt;
  logic [DW-1:0]    rd_q;
  logic             rd_v;
  logic             err_q;

  logic             cmd_fire;
  logic             cmd_legal;
  logic             wr_fire;

  assign cmd_fire  = (state == ST_IDLE) && bus.cmd_valid;
  assign cmd_legal = (bus.cmd_len != '0) && (bus.cmd_len <= MAX_LEN);
  assign wr_fire   = (state == ST_WR) && bus.wr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      rd_q  <= '0;
      rd_v  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            ptr <= bus.cmd_addr;
            cnt <= bus.cmd_len;
            if (cmd_legal) begin
              state <= bus.cmd_write ? ST_WR : ST_RD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (bus.wr_valid) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_ONE) begin
              state <= ST_FIN;
            end
          end
        end
        ST_RD: begin
          rd_q  <= mem_rdata;
          rd_v  <= 1'b1;
          ptr   <= ptr + 1'b1;
          cnt   <= cnt - 1'b1;
          state <= ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          if (bus.rd_ready) begin
            rd_v  <= 1'b0;
            state <= (cnt == '0) ? ST_FIN : ST_RD;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM pins are idle-zero so nothing but a live beat ever reaches ram8.
  always_comb begin
    mem_en    = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_fire) begin
      mem_en    = 1'b1;
      mem_addr  = ptr;
      mem_wdata = bus.wr_data;
    end else if (state == ST_RD) begin
      mem_en   = 1'b1;
      mem_read = 1'b1;
      mem_addr = ptr;
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.wr_ready  = (state == ST_WR);
  assign bus.rd_valid  = rd_v;
  assign bus.rd_data   = rd_q;
  assign bus.done      = (state == ST_FIN);
  assign bus.err       = err_q;

  a_rd_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rd_valid && !bus.rd_ready) |=> (bus.rd_valid && $stable(bus.rd_data)));

  a_err_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.err && bus.done));

  a_mem_busy_only: assert property (@(posedge clk) disable iff (!rst_n)
    mem_en |-> !bus.cmd_ready);

endmodule

// File: tb/tb_ram8_ctrl.sv
// Randomized self-checking bench: ram8_ctrl driving a real ram8, compared
// against an array model of memory contents and the burst timing rules.
module tb_ram8_ctrl;
  import ram8_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mem_en, mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ram8_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ram8_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  ram8 #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .en      (mem_en),
    .read    (mem_read),
    .address (mem_addr),
    .in      (mem_wdata),
    .out     (mem_rdata)
  );

  logic [DW-1:0] model [RAM8_DEPTH];
  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.err || bus.done)) check("err_done_excl", 32'(bus.err && bus.done), 32'd0);
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
    check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({tag, "_rd_data"},   bus.rd_data,        32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_err"},       32'(bus.err),       32'd0);
    check({tag, "_mem_en"},    32'(mem_en),        32'd0);
    check({tag, "_mem_read"},  32'(mem_read),      32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),      32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
  endtask

  // Offer a command in IDLE; returns at posedge+1 with the command accepted.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [AW:0] l);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    @(negedge clk);
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_burst();
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("fin_mem_en", 32'(mem_en), 32'd0);
    check("fin_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("fin_err", 32'(bus.err), 32'd0);
    check("fin_rd_valid", 32'(bus.rd_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_cleared", 32'(bus.done), 32'd0);
    check("back_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d[$], input bit gaps);
    int unsigned   i = 0;
    logic [AW-1:0] p = a;
    bit            v;
    issue(1'b1, a, (AW+1)'(d.size()));
    while (i < d.size()) begin
      v = !(gaps && ($urandom_range(2, 0) == 0));
      bus.wr_valid = v;
      bus.wr_data  = v ? d[i] : $urandom;
      @(negedge clk);
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      check("wr_mem_en", 32'(mem_en), 32'(v));
      if (v) begin
        check("wr_addr", 32'(mem_addr), 32'(p));
        check("wr_wdata", mem_wdata, d[i]);
        check("wr_mem_read", 32'(mem_read), 32'd0);
      end
      check("wr_no_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      if (v) begin
        model[p] = d[i];
        p = p + 1'b1;
        i++;
      end
    end
    bus.wr_valid = 1'b0;
    finish_burst();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int unsigned len,
                         input int unsigned stall_lo, input int unsigned stall_hi);
    logic [AW-1:0] p = a;
    int unsigned   st;
    issue(1'b0, a, (AW+1)'(len));
    for (int unsigned i = 0; i < len; i++) begin
      bus.rd_ready = 1'b0;
      @(negedge clk);
      check("rd_mem_en", 32'(mem_en), 32'd1);
      check("rd_mem_read", 32'(mem_read), 32'd1);
      check("rd_addr", 32'(mem_addr), 32'(p));
      check("rd_valid_low", 32'(bus.rd_valid), 32'd0);
      @(posedge clk); #1;
      st = $urandom_range(stall_hi, stall_lo);
      for (int unsigned s = 0; s < st; s++) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.rd_valid), 32'd1);
        check("hold_data", bus.rd_data, model[p]);
        check("hold_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
      end
      bus.rd_ready = 1'b1;
      @(negedge clk);
      check("rd_valid", 32'(bus.rd_valid), 32'd1);
      check("rd_data", bus.rd_data, model[p]);
      check("rd_hs_mem_en", 32'(mem_en), 32'd0);
      @(posedge clk); #1;
      bus.rd_ready = 1'b0;
      p = p + 1'b1;
    end
    finish_burst();
  endtask

  task automatic bad_cmd(input logic [AW:0] l);
    issue(1'($urandom), AW'($urandom), l);
    @(negedge clk);
    check("err_pulse", 32'(bus.err), 32'd1);
    check("err_mem_en", 32'(mem_en), 32'd0);
    check("err_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("err_no_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_cleared", 32'(bus.err), 32'd0);
    check("err_idle_mem_en", 32'(mem_en), 32'd0);
    check("err_idle_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] d[$];
  logic [AW-1:0] p;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    d = {};
    for (int unsigned i = 0; i < RAM8_DEPTH; i++) d.push_back($urandom);
    do_write(3'd0, d, 1'b0);

    d = {32'hA1, 32'hA2, 32'hA3};
    do_write(3'd2, d, 1'b0);
    do_read(3'd2, 3, 0, 0);

    d = {32'h10, 32'h11, 32'h12, 32'h13};
    do_write(3'd6, d, 1'b0);
    do_read(3'd0, 1, 0, 0);
    do_read(3'd5, 8, 0, 0);

    do_read(3'd0, 4, 5, 5);
    d = {};
    for (int unsigned i = 0; i < 5; i++) d.push_back($urandom);
    do_write(3'd1, d, 1'b1);
    do_read(3'd1, 5, 0, 2);

    bad_cmd(4'd0);
    bad_cmd(4'd9);
    bad_cmd(4'd15);

    // Reset two beats into a five-word write.
    p = 3'd3;
    issue(1'b1, p, 4'd5);
    for (int unsigned i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = $urandom;
      model[p] = bus.wr_data;
      @(posedge clk); #1;
      p = p + 1'b1;
    end
    bus.wr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_no_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    do_read(3'd3, 5, 0, 0);

    repeat (40) begin
      int unsigned kind = $urandom_range(5, 0);
      logic [AW-1:0] a = AW'($urandom);
      int unsigned len = $urandom_range(RAM8_DEPTH, 1);
      if (kind == 0) begin
        bad_cmd(($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 9)));
      end else if (kind < 3) begin
        d = {};
        for (int unsigned i = 0; i < len; i++) d.push_back($urandom);
        do_write(a, d, 1'b1);
      end else begin
        do_read(a, len, 0, 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram8_ctrl.md
# ram8_ctrl

Sequencing front end for the 8 x 32-bit `ram8` register file. It accepts burst read/write commands over a valid/ready interface and drives the RAM's enable, read, address and data pins word by word. Write data arrives on a valid/ready stream and read data leaves on one. It sits between the CPU datapath or any other bus initiator and `ram8`, and is the only block allowed to drive the RAM pins.

## Interface
Parameters
- `DW`, 32: data width; must match `ram8`.
- `AW`, 3: address width; depth is 2^AW = 8.

Ports
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, **synchronous, active-low**.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` input 1: 1 = write burst, 0 = read burst.
- `cmd_addr` input AW: start address.
- `cmd_len` input AW+1: word count; legal range 1..8.
- `wr_valid` input 1, `wr_ready` output 1, `wr_data` input DW: write data stream.
- `rd_valid` output 1, `rd_ready` input 1, `rd_data` output DW: read data stream.
- `done` output 1: one-cycle pulse after the last word of a burst.
- `err` output 1: one-cycle pulse when an illegal command is rejected.
- `mem_en`, `mem_read` output 1; `mem_addr` output AW; `mem_wdata` output DW; `mem_rdata` input DW: connect to `ram8` `en`, `read`, `address`, `in` and `out`.

## Operation
- States are IDLE, WR, RD, RD_HOLD and FIN.
- **IDLE**
  - `cmd_ready`=1.
  - On handshake, latch `cmd_addr` into `ptr`, `cmd_len` into `cnt` and `cmd_write`.
  - `cmd_len`==0 or >8: pulse `err` next cycle, stay in IDLE, issue no RAM access.
  - Otherwise go to WR or RD.
- **WR**
  - `wr_ready`=1.
  - Each cycle with `wr_valid`: `mem_en`=1, `mem_read`=0, `mem_addr`=`ptr`, `mem_wdata`=`wr_data` (combinational pass-through).
  - On that clock edge `ram8` stores the word, `ptr` increments and `cnt` decrements.
  - `wr_valid`=0: `mem_en`=0 and no state change.
  - When the `cnt`==1 beat is accepted, go to FIN.
- **RD**
  - `mem_en`=1, `mem_read`=1, `mem_addr`=`ptr`.
  - `mem_rdata` is captured into `rd_data` at the clock edge; `rd_valid` is set, `ptr` increments and `cnt` decrements.
  - Then go to RD_HOLD.
- **RD_HOLD**
  - `mem_en`=0 and `rd_valid`=1; `rd_data` holds.
  - On `rd_ready`: `rd_valid` clears; go to FIN if `cnt`==0, else back to RD.
- **FIN**: `done`=1 for one cycle, then IDLE.
- `ptr` is AW bits and wraps 7 -> 0. A burst of 8 from address 5 touches 5,6,7,0,1,2,3,4.
- `mem_en`=0 in every state except the WR beat and RD. A write and a read never overlap.
- `cmd_ready`=0 outside IDLE. Commands are never queued.

## Timing
- Reset values: `cmd_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `done`=0, `err`=0, `mem_en`=0, `mem_read`=0, `mem_addr`=0, `mem_wdata`=0. State is IDLE.
- `rst_n` low mid-burst:
  - The FSM returns to IDLE on that edge.
  - The partial burst is abandoned and words already written stay written.
  - No `done` pulse is issued.
- Write latency: word k is visible in `ram8` on the edge that accepts beat k. Best case is one word per cycle.
- Read latency: 1 cycle from RD entry to `rd_valid`. Throughput is at most one word per 2 cycles.
- `done` is asserted the cycle after the final beat (write) or the final `rd_ready` handshake (read).
- A command accepted in IDLE produces the first RAM access on the next cycle.
- `rd_data` and `rd_valid` are stable while `rd_valid && !rd_ready`.
- `err` and `done` never assert in the same cycle.

## Structure
- Shared package `ram8_pkg`:
  - `DW` and `AW` constants.
  - FSM state enum `ram8_ctrl_state_t`.
  - `RAM8_DEPTH`=8.
- No sub-module is required: the FSM, `ptr` and `cnt` counters and the read holding register live in one module.
- Bench instantiates `ram8_ctrl` driving a real `ram8`.

## Test plan
- Write burst: addr 2, len 3, data 0xA1,0xA2,0xA3 with `wr_valid` held high -> three consecutive `mem_en` cycles at addresses 2,3,4. `done` pulses 1 cycle after the last beat.
- Read-back: read addr 2, len 3 with `rd_ready`=1 -> `rd_data` is 0xA1,0xA2,0xA3, one word every 2 cycles, then `done`.
- Wrap: write addr 6, len 4 of 0x10..0x13 -> addresses 6,7,0,1. Reading addr 0 len 1 returns 0x12.
- Backpressure: during a read, hold `rd_ready` low for 5 cycles -> `rd_data` is stable and `mem_en`=0 throughout. A write with `wr_valid` gaps issues no `mem_en` in the gap cycles.
- Illegal length: `cmd_len`=0, then `cmd_len`=9 -> `err` pulses once each, `mem_en` never asserts, and `cmd_ready` stays 1.
- Reset mid-burst: after 2 of 5 write beats, pull `rst_n` low for 1 cycle -> all outputs take their reset values and no `done` pulse is issued. Reading back shows only the first 2 words updated.
